mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Consumer side of the EX/MEM pipeline register. Takes the registered EX/MEM outputs and performs the data-memory access for load and store instructions over a req/ready data bus.
- Formats load data and produces the MEM/WB-facing result.
- Non-memory instructions pass through with one cycle of latency.
- Asserts stall_out to hold the EX/MEM register and all earlier stages while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: REQ cycles without dmem_ready before the access is aborted with bus_err_out. 0 disables the timeout.
- CNT_W, 16: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_in  in  1  EX/MEM slot holds a live instruction
- instr_id_in  in  6  instruction id; load/store codes come from the shared package
- pc_in  in  32  instruction PC
- mem_addr_in  in  32  effective address
- rs2_value_in  in  32  store data
- exec_output_in  in  32  ALU result
- rd_addr_in  in  5  destination register
- rd_valid_in  in  1  instruction writes rd
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables
- dmem_ready  in  1  bus completes the request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready = 1
- stall_out  out  1  freeze upstream (combinational)
- valid_out  out  1  MEM/WB slot valid
- pc_out  out  32  PC of the retiring instruction
- rd_addr_out  out  5  destination register
- rd_valid_out  out  1  writeback enable
- wb_data_out  out  32  load data or ALU result
- misalign_out  out  1  misaligned access flagged
- bus_err_out  out  1  bus timeout flagged

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset forces:
  - FSM to IDLE
  - all registered outputs to 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
  - timeout counter to 0
  - Reset mid-transaction drops dmem_req immediately. The bus must tolerate an abandoned request.
- FSM states: IDLE, REQ.
- IDLE, valid_in = 0: next edge sets valid_out = 0 and rd_valid_out = 0. stall_out = 0.
- IDLE, valid non-memory op: next edge sets
  - valid_out = 1
  - wb_data_out = exec_output_in
  - rd_addr_out, rd_valid_out, pc_out copied from the inputs
  - stall_out = 0
- IDLE, valid memory op, misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0):
  - no bus access and stall_out = 0
  - next edge sets valid_out = 1, misalign_out = 1, rd_valid_out = 0
- IDLE, valid aligned memory op:
  - stall_out = 1 this cycle
  - next edge: state goes to REQ; dmem_req = 1; dmem_addr, dmem_we, dmem_wdata, dmem_wstrb latched; valid_out = 0 (bubble)
- REQ:
  - dmem_req and all request fields held stable; inputs ignored
  - stall_out = !dmem_ready
  - On dmem_ready = 1, the next edge:
    - sets dmem_req = 0 and returns to IDLE
    - sets valid_out = 1 and pc_out / rd_addr_out from the latched request
    - for loads: rd_valid_out = latched rd_valid, wb_data_out = formatted load data
    - for stores: rd_valid_out = 0
  - The same edge loads the next instruction into EX/MEM, so the held memory op is never reissued.
- Timeout: the counter increments every REQ cycle without dmem_ready. When it reaches TIMEOUT_CYCLES:
  - stall_out = 0 that cycle
  - next edge: IDLE, dmem_req = 0, valid_out = 1, bus_err_out = 1, rd_valid_out = 0
  - counter clears on leaving REQ
- Store strobes and data:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}
  - SH: wstrb = 4'b0011 << (2*addr[1]); wdata = {2{rs2[15:0]}}
  - SW: wstrb = 4'b1111; wdata = rs2
  - Loads: wstrb = 0, we = 0.
- Load formatting, using latched addr[1:0]:
  - LB/LBU select byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU select halfword lane addr[1]; LH sign-extends, LHU zero-extends.
  - LW passes the full word.
- misalign_out and bus_err_out are single-cycle flags, qualified by valid_out.

Decomposition:
- Shared package holds:
  - instr_id constants INSTR_LB, LH, LW, LBU, LHU, SB, SH, SW
  - is_load / is_store helper functions
  - the FSM state encoding
- One sub-module, mem_lane_align (combinational), does store strobe/data generation and load extraction/extension. The FSM, timeout counter and output registers live in the top module.

Test Plan:
- ALU op: valid_in = 1, non-memory id, exec_output = 0x1234, rd = 5 -> next cycle valid_out = 1, wb_data_out = 0x1234, rd_valid_out = 1, stall_out never asserted.
- LB at address 0x1003, dmem_ready held low 2 REQ cycles, rdata = 0x80FFFFFF -> stall_out high 3 cycles; then valid_out = 1, wb_data_out = 0xFFFFFF80, dmem_addr = 0x1000.
- SH at address 0x2002, rs2 = 0xABCD1234, ready on the first REQ cycle -> dmem_wstrb = 4'b1100, dmem_wdata = 0x12341234, dmem_we = 1; then valid_out = 1, rd_valid_out = 0.
- LW at address 0x3001 -> no dmem_req; next cycle misalign_out = 1, valid_out = 1, rd_valid_out = 0, stall_out = 0.
- TIMEOUT_CYCLES = 4, LW with dmem_ready stuck low -> dmem_req high for 4 cycles; then bus_err_out = 1, valid_out = 1, dmem_req = 0.
- rst pulsed during REQ -> dmem_req = 0 and all outputs 0 immediately; after release a new LBU at 0x0 with rdata = 0x000000F0 returns 0x000000F0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: memory instruction ids, decode helpers
// and the access FSM encoding.
package mem_access_unit_pkg;

    localparam logic [5:0] INSTR_LB  = 6'h20;
    localparam logic [5:0] INSTR_LH  = 6'h21;
    localparam logic [5:0] INSTR_LW  = 6'h22;
    localparam logic [5:0] INSTR_LBU = 6'h24;
    localparam logic [5:0] INSTR_LHU = 6'h25;
    localparam logic [5:0] INSTR_SB  = 6'h28;
    localparam logic [5:0] INSTR_SH  = 6'h29;
    localparam logic [5:0] INSTR_SW  = 6'h2A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mau_state_e;

    function automatic logic is_load(input logic [5:0] id);
        return (id == INSTR_LB) || (id == INSTR_LH) || (id == INSTR_LW) ||
               (id == INSTR_LBU) || (id == INSTR_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] id);
        return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] id, input logic [1:0] off);
        logic half, word;
        half = (id == INSTR_LH) || (id == INSTR_LHU) || (id == INSTR_SH);
        word = (id == INSTR_LW) || (id == INSTR_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: store strobe/data replication and load lane extraction
// with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  st_id_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_strb_o,
    output logic [31:0] st_wdata_o,
    input  logic [5:0]  ld_id_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_strb_o  = 4'b0000;
        st_wdata_o = st_data_i;
        case (st_id_i)
            INSTR_SB: begin
                st_strb_o  = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            INSTR_SH: begin
                st_strb_o  = 4'b0011 << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            INSTR_SW: st_strb_o = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    byte_sel = ld_rdata_i[7:0];
            2'd1:    byte_sel = ld_rdata_i[15:8];
            2'd2:    byte_sel = ld_rdata_i[23:16];
            default: byte_sel = ld_rdata_i[31:24];
        endcase
        half_sel = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_id_i)
            INSTR_LB:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            INSTR_LBU: ld_data_o = {24'h000000, byte_sel};
            INSTR_LH:  ld_data_o = {{16{half_sel[15]}}, half_sel};
            INSTR_LHU: ld_data_o = {16'h0000, half_sel};
            default:   ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues load/store over the req/ready data bus, stalls upstream
// while a request is outstanding and registers the MEM/WB result.
//   state   | meaning
//   ST_IDLE | accepting EX/MEM slot; non-memory ops and misaligned ops retire next edge
//   ST_REQ  | bus request held; waiting for dmem_ready or timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  instr_id_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] rs2_value_in,
    input  logic [31:0] exec_output_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        rd_valid_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_addr_out,
    output logic        rd_valid_out,
    output logic [31:0] wb_data_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    mau_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_op, misal, timeout;
    logic [3:0]       st_strb;
    logic [31:0]      st_wdata, ld_data;

    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [5:0]  ld_id_q, ld_id_d;
    logic [1:0]  off_q, off_d;
    logic        rdv_lat_q, rdv_lat_d;
    logic        valid_q, valid_d, rdv_q, rdv_d, misal_q, misal_d, err_q, err_d;
    logic [31:0] pc_q, pc_d, wb_q, wb_d;
    logic [4:0]  rd_q, rd_d;

    mem_lane_align u_lane (
        .st_id_i    (instr_id_in),
        .st_off_i   (mem_addr_in[1:0]),
        .st_data_i  (rs2_value_in),
        .st_strb_o  (st_strb),
        .st_wdata_o (st_wdata),
        .ld_id_i    (ld_id_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (dmem_rdata),
        .ld_data_o  (ld_data)
    );

    assign mem_op  = valid_in && (is_load(instr_id_in) || is_store(instr_id_in));
    assign misal   = is_misaligned(instr_id_in, mem_addr_in[1:0]);
    // Fires in the cycle whose missing ready would bring the count to the limit.
    assign timeout = (TIMEOUT_CYCLES != 0) && !dmem_ready && ((cnt_q + CNT_W'(1)) == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op && !misal) state_d = ST_REQ;
            ST_REQ:  if (dmem_ready || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cnt_d = (state_q == ST_REQ && state_d == ST_REQ) ? cnt_q + CNT_W'(1) : '0;
    end

    always_comb begin
        stall_out = 1'b0;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ld_id_d   = ld_id_q;
        off_d     = off_q;
        rdv_lat_d = rdv_lat_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        valid_d   = 1'b0;
        rdv_d     = 1'b0;
        misal_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_out = mem_op && !misal;
                if (valid_in) begin
                    pc_d = pc_in;
                    rd_d = rd_addr_in;
                    if (mem_op && misal) begin
                        valid_d = 1'b1;
                        misal_d = 1'b1;
                    end else if (mem_op) begin
                        req_d     = 1'b1;
                        we_d      = is_store(instr_id_in);
                        addr_d    = {mem_addr_in[31:2], 2'b00};
                        wdata_d   = st_wdata;
                        wstrb_d   = st_strb;
                        ld_id_d   = instr_id_in;
                        off_d     = mem_addr_in[1:0];
                        rdv_lat_d = rd_valid_in;
                    end else begin
                        valid_d = 1'b1;
                        wb_d    = exec_output_in;
                        rdv_d   = rd_valid_in;
                    end
                end
            end
            ST_REQ: begin
                stall_out = !dmem_ready && !timeout;
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    if (!we_q) begin
                        rdv_d = rdv_lat_q;
                        wb_d  = ld_data;
                    end
                end else if (timeout) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ld_id_q   <= '0;
            off_q     <= '0;
            rdv_lat_q <= 1'b0;
            valid_q   <= 1'b0;
            rdv_q     <= 1'b0;
            misal_q   <= 1'b0;
            err_q     <= 1'b0;
            pc_q      <= '0;
            rd_q      <= '0;
            wb_q      <= '0;
        end else begin
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ld_id_q   <= ld_id_d;
            off_q     <= off_d;
            rdv_lat_q <= rdv_lat_d;
            valid_q   <= valid_d;
            rdv_q     <= rdv_d;
            misal_q   <= misal_d;
            err_q     <= err_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign valid_out    = valid_q;
    assign pc_out       = pc_q;
    assign rd_addr_out  = rd_q;
    assign rd_valid_out = rdv_q;
    assign wb_data_out  = wb_q;
    assign misalign_out = misal_q;
    assign bus_err_out  = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset-in-REQ
// sequence, then randomized instructions checked against a rule-level model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, rd_valid_in, dmem_ready;
    logic [5:0]  instr_id_in;
    logic [31:0] pc_in, mem_addr_in, rs2_value_in, exec_output_in, dmem_rdata;
    logic [4:0]  rd_addr_in;
    logic        dmem_req, dmem_we, stall_out, valid_out, rd_valid_out, misalign_out, bus_err_out;
    logic [31:0] dmem_addr, dmem_wdata, pc_out, wb_data_out;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_addr_out;

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instr_id_in(instr_id_in),
        .pc_in(pc_in), .mem_addr_in(mem_addr_in), .rs2_value_in(rs2_value_in),
        .exec_output_in(exec_output_in), .rd_addr_in(rd_addr_in), .rd_valid_in(rd_valid_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .valid_out(valid_out),
        .pc_out(pc_out), .rd_addr_out(rd_addr_out), .rd_valid_out(rd_valid_out),
        .wb_data_out(wb_data_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr, rs2, exec, pc;
        logic [4:0]  rd;
        logic        rdv;
        int          lat;
        logic [31:0] rdata;
        logic        e_mem, e_misal, e_err, e_we, e_rdv, e_chkwb;
        logic [31:0] e_addr, e_wdata, e_wb;
        logic [3:0]  e_strb;
    } vec_t;

    function automatic vec_t mkv(input logic [5:0] id, input logic [31:0] addr, rs2, exec,
                                 input logic [4:0] rd, input logic rdv, input int lat,
                                 input logic [31:0] rdata, input logic e_mem, e_misal, e_err,
                                 input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                                 input logic [31:0] e_wdata, e_wb, input logic e_rdv, e_chkwb);
        vec_t v;
        v.id = id; v.addr = addr; v.rs2 = rs2; v.exec = exec; v.pc = 32'h0;
        v.rd = rd; v.rdv = rdv; v.lat = lat; v.rdata = rdata;
        v.e_mem = e_mem; v.e_misal = e_misal; v.e_err = e_err; v.e_addr = e_addr;
        v.e_we = e_we; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_wb = e_wb;
        v.e_rdv = e_rdv; v.e_chkwb = e_chkwb;
        return v;
    endfunction

    // Expectations from the access rules, using plain lane arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit ld, st, sgn;
        int unsigned off, size, shift;
        longint unsigned val;
        ld = (v.id == INSTR_LB) || (v.id == INSTR_LH) || (v.id == INSTR_LW) ||
             (v.id == INSTR_LBU) || (v.id == INSTR_LHU);
        st = (v.id == INSTR_SB) || (v.id == INSTR_SH) || (v.id == INSTR_SW);
        off = v.addr % 4;
        size = (v.id inside {INSTR_LB, INSTR_LBU, INSTR_SB}) ? 8 :
               (v.id inside {INSTR_LH, INSTR_LHU, INSTR_SH}) ? 16 : 32;
        r.e_misal = (ld || st) && ((off % (size / 8)) != 0);
        r.e_mem   = (ld || st) && !r.e_misal;
        r.e_err   = r.e_mem && (v.lat >= TO);
        r.e_addr  = v.addr - off;
        r.e_we    = st;
        shift     = (off / (size / 8)) * size;
        r.e_strb  = st ? 4'(((1 << (size / 8)) - 1) << (shift / 8)) : 4'h0;
        r.e_wdata = (size == 8)  ? (v.rs2 % 256) * 32'h01010101 :
                    (size == 16) ? (v.rs2 % 65536) * 32'h00010001 : v.rs2;
        val = (longint'(v.rdata) >> shift) % (64'd1 << size);
        sgn = ((v.id == INSTR_LB) || (v.id == INSTR_LH)) && (val >= (64'd1 << (size - 1)));
        if (sgn) val = val + 64'h1_0000_0000 - (64'd1 << size);
        r.e_chkwb = (!ld && !st) || (ld && r.e_mem && !r.e_err);
        r.e_rdv   = r.e_chkwb ? v.rdv : 1'b0;
        r.e_wb    = (!ld && !st) ? v.exec : 32'(val);
        return r;
    endfunction

    task automatic drive_junk();
        valid_in       = 1'($urandom);
        instr_id_in    = 6'($urandom);
        pc_in          = $urandom;
        mem_addr_in    = $urandom;
        rs2_value_in   = $urandom;
        exec_output_in = $urandom;
        rd_addr_in     = 5'($urandom);
        rd_valid_in    = 1'($urandom);
    endtask

    task automatic idle_cycle();
        valid_in = 1'b0; dmem_ready = 1'b0;
        #1 chk("idle_stall", 32'(stall_out), 32'h0);
        @(posedge clk); #1;
        chk("idle_valid", 32'(valid_out), 32'h0);
        chk("idle_rdv", 32'(rd_valid_out), 32'h0);
    endtask

    task automatic check_retire(input vec_t v);
        chk("ret_valid", 32'(valid_out), 32'h1);
        chk("ret_misal", 32'(misalign_out), 32'(v.e_misal));
        chk("ret_buserr", 32'(bus_err_out), 32'(v.e_err));
        chk("ret_rdv", 32'(rd_valid_out), 32'(v.e_rdv));
        chk("ret_pc", pc_out, v.pc);
        chk("ret_rd", 32'(rd_addr_out), 32'(v.rd));
        chk("ret_req", 32'(dmem_req), 32'h0);
        if (v.e_chkwb) chk("ret_wb", wb_data_out, v.e_wb);
    endtask

    // Called just after a rising edge; returns just after the retiring edge.
    task automatic run_vec(input vec_t v);
        bit done = 0;
        valid_in = 1'b1; instr_id_in = v.id; pc_in = v.pc; mem_addr_in = v.addr;
        rs2_value_in = v.rs2; exec_output_in = v.exec; rd_addr_in = v.rd;
        rd_valid_in = v.rdv; dmem_ready = 1'b0; dmem_rdata = $urandom;
        #1 chk("issue_stall", 32'(stall_out), 32'(v.e_mem));
        @(posedge clk); #1;
        if (!v.e_mem) begin
            check_retire(v);
            return;
        end
        chk("req_bubble", 32'(valid_out), 32'h0);
        chk("req_on", 32'(dmem_req), 32'h1);
        chk("req_addr", dmem_addr, v.e_addr);
        chk("req_we", 32'(dmem_we), 32'(v.e_we));
        chk("req_strb", 32'(dmem_wstrb), 32'(v.e_strb));
        if (v.e_we) chk("req_wdata", dmem_wdata, v.e_wdata);
        for (int k = 0; k < 64 && !done; k++) begin
            bit rdy, to;
            rdy = (k == v.lat);
            to  = !rdy && (k + 1 == TO);
            drive_junk();
            dmem_ready = rdy;
            dmem_rdata = rdy ? v.rdata : $urandom;
            #1 chk("req_stall", 32'(stall_out), 32'(!(rdy || to)));
            @(posedge clk); #1;
            if (rdy || to) begin
                done = 1;
                check_retire(v);
            end else begin
                chk("hold_req", 32'(dmem_req), 32'h1);
                chk("hold_addr", dmem_addr, v.e_addr);
                chk("hold_bubble", 32'(valid_out), 32'h0);
            end
        end
        if (!done) chk("req_bound", 32'h0, 32'h1);
        dmem_ready = 1'b0;
    endtask

    vec_t tbl[$];
    logic [5:0] ids[11];

    initial begin
        vec_t v;
        ids = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
                INSTR_SB, INSTR_SH, INSTR_SW, 6'h01, 6'h13, 6'h33};
        //            id         addr          rs2           exec          rd  rdv lat  rdata         mem mis err e_addr       we  strb   e_wdata       e_wb          rdv chkwb
        tbl.push_back(mkv(6'h01,     32'h0,       32'h0,        32'h1234,     5,  1,  0,   32'h0,        0,  0,  0,  32'h0,       0,  4'h0,  32'h0,        32'h1234,     1,  1));
        tbl.push_back(mkv(INSTR_LB,  32'h1003,    32'h0,        32'h0,        7,  1,  2,   32'h80FFFFFF, 1,  0,  0,  32'h1000,    0,  4'h0,  32'h0,        32'hFFFFFF80, 1,  1));
        tbl.push_back(mkv(INSTR_SH,  32'h2002,    32'hABCD1234, 32'h0,        3,  1,  0,   32'h0,        1,  0,  0,  32'h2000,    1,  4'hC,  32'h12341234, 32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_LW,  32'h3001,    32'h0,        32'h0,        9,  1,  0,   32'h0,        0,  1,  0,  32'h0,       0,  4'h0,  32'h0,        32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_LW,  32'h4000,    32'h0,        32'h0,        10, 1,  100, 32'h0,        1,  0,  1,  32'h4000,    0,  4'h0,  32'h0,        32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_LHU, 32'h5002,    32'h0,        32'h0,        11, 1,  1,   32'h87654321, 1,  0,  0,  32'h5000,    0,  4'h0,  32'h0,        32'h00008765, 1,  1));
        tbl.push_back(mkv(INSTR_LH,  32'h5000,    32'h0,        32'h0,        12, 1,  0,   32'h12348001, 1,  0,  0,  32'h5000,    0,  4'h0,  32'h0,        32'hFFFF8001, 1,  1));
        tbl.push_back(mkv(INSTR_SB,  32'h6001,    32'h000000A5, 32'h0,        13, 1,  2,   32'h0,        1,  0,  0,  32'h6000,    1,  4'h2,  32'hA5A5A5A5, 32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_SW,  32'h7000,    32'hDEADBEEF, 32'h0,        14, 0,  3,   32'h0,        1,  0,  0,  32'h7000,    1,  4'hF,  32'hDEADBEEF, 32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_LW,  32'h8000,    32'h0,        32'h0,        15, 1,  4,   32'h11111111, 1,  0,  1,  32'h8000,    0,  4'h0,  32'h0,        32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_LH,  32'h5001,    32'h0,        32'h0,        16, 1,  0,   32'h0,        0,  1,  0,  32'h0,       0,  4'h0,  32'h0,        32'h0,        0,  0));
        tbl.push_back(mkv(INSTR_SH,  32'h2003,    32'h0,        32'h0,        17, 0,  0,   32'h0,        0,  1,  0,  32'h0,       0,  4'h0,  32'h0,        32'h0,        0,  0));
        tbl.push_back(mkv(6'h33,     32'h0,       32'h0,        32'hCAFEF00D, 0,  0,  0,   32'h0,        0,  0,  0,  32'h0,       0,  4'h0,  32'h0,        32'hCAFEF00D, 0,  1));
        tbl.push_back(mkv(INSTR_LBU, 32'h9002,    32'h0,        32'h0,        18, 1,  0,   32'h11223344, 1,  0,  0,  32'h9000,    0,  4'h0,  32'h0,        32'h00000022, 1,  1));

        rst = 1'b1; valid_in = 1'b0; instr_id_in = '0; pc_in = '0; mem_addr_in = '0;
        rs2_value_in = '0; exec_output_in = '0; rd_addr_in = '0; rd_valid_in = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            v = tbl[i];
            v.pc = 32'h100 + 32'(i) * 4;
            run_vec(v);
        end
        idle_cycle();

        // Reset while a request is outstanding, then a fresh load.
        v = mkv(INSTR_LW, 32'hA000, 32'h0, 32'h0, 4, 1, 0, 32'h0, 1, 0, 0, 32'hA000, 0, 4'h0, 32'h0, 32'h0, 1, 1);
        valid_in = 1'b1; instr_id_in = v.id; mem_addr_in = v.addr; rd_addr_in = v.rd; rd_valid_in = 1'b1;
        @(posedge clk); #1;
        chk("rstreq_pre", 32'(dmem_req), 32'h1);
        valid_in = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstreq_req", 32'(dmem_req), 32'h0);
        chk("rstreq_addr", dmem_addr, 32'h0);
        chk("rstreq_we", 32'(dmem_we), 32'h0);
        chk("rstreq_valid", 32'(valid_out), 32'h0);
        chk("rstreq_stall", 32'(stall_out), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        v = mkv(INSTR_LBU, 32'h0, 32'h0, 32'h0, 6, 1, 1, 32'h000000F0, 1, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h000000F0, 1, 1);
        v.pc = 32'h200;
        run_vec(v);

        for (int n = 0; n < 200; n++) begin
            v.id = ids[$urandom_range(0, 10)];
            v.addr = $urandom; v.rs2 = $urandom; v.exec = $urandom; v.pc = $urandom;
            v.rd = 5'($urandom); v.rdv = 1'($urandom);
            v.lat = $urandom_range(0, 5); v.rdata = $urandom;
            run_vec(model(v));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
